ex_muldiv: RTL and testbench
============================

# ex_muldiv

Iterative multiply/divide unit with the HI/LO register pair, in the EX stage of the 5-stage MIPS pipeline. It consumes the mult/div operation and operands held in the ID/EX pipeline register. While an operation is in flight it drives `exe_stall` back to the ID/EX register, freezing that register and the stages before it. Results are delivered in architectural HI/LO registers readable by MFHI/MFLO.

## Interface
Parameters:
- none (datapath fixed at 32 bits; 32 iterations)

Ports (clock and reset first):
- `clk`  in  1  clock; all state updates on the rising edge.
- `resetn`  in  1  reset: synchronous, active-low.
- `start`  in  1  EX-stage instruction is MULT/MULTU/DIV/DIVU; held high while that instruction sits in EX.
- `op`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a`  in  32  rs operand (multiplicand/dividend).
- `b`  in  32  rt operand (multiplier/divisor).
- `hilo_we`  in  2  direct write for MTHI/MTLO: [1] writes HI, [0] writes LO.
- `hilo_wdata`  in  32  data for `hilo_we` writes.
- `flush`  in  1  abort any in-flight operation.
- `exe_stall`  out  1  to ID/EX register: hold pipeline.
- `done`  out  1  one-cycle pulse: result committed, instruction may leave EX.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- States: IDLE, CALC, SIGN, DONE.
- IDLE:
  - If `start` is high and `flush` is low, latch `op`, the sign flags of `a` and `b`, and magnitudes |a|, |b| (magnitudes only for signed ops).
  - Clear the accumulator and set the iteration counter (5 bits) to 0, then go to CALC.
- CALC: one iteration per cycle; after iteration with count==31, go to SIGN.
  - Multiply: radix-2 shift-add into a 64-bit accumulator.
  - Divide: restoring division producing a 32-bit quotient and 32-bit remainder.
- SIGN:
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: negate the quotient if the signs differ; the remainder takes the sign of the dividend.
  - Commit results: multiply writes {HI,LO} = product; divide writes LO = quotient, HI = remainder. Then go to DONE.
- DONE: `done`=1 and `exe_stall`=0. `start` is ignored in this cycle; the instruction advances on this edge. Next state is IDLE.
- `exe_stall` = (IDLE & `start` & !`flush`) | CALC | SIGN. It is combinational, so the ID/EX register holds from the first EX cycle.
- Divide by zero (`b`==0): LO=32'hFFFFFFFF, HI=original `a`. Latency is the same; no exception.
- 0x80000000 / 0xFFFFFFFF (DIV): LO=32'h80000000, HI=0 (wraps naturally).
- `hilo_we`: written only in IDLE, with the DONE commit taking priority. Writes are ignored in CALC/SIGN; the pipeline is stalled then, so they cannot occur legally.
- `flush` in CALC/SIGN: return to IDLE next edge; HI/LO unchanged, `done` not pulsed.
- `resetn` low (any state): state=IDLE, counter=0, HI=LO=0, `done`=0. `exe_stall`=0 while in reset.

## Timing
- Cycle 0 = first cycle `start` is seen in IDLE; `exe_stall` high in cycles 0–33 (34 cycles).
  - Cycles 1–32: CALC.
  - Cycle 33: SIGN; HI/LO updated at the end of this cycle.
  - Cycle 34: DONE, with `done`=1 and new HI/LO visible.
- Back-to-back mult/div: the next instruction enters EX after cycle 34. It is seen in IDLE at cycle 35, so there is no idle bubble beyond DONE.
- MFHI/MFLO in the EX cycle after DONE reads the committed values; no extra forwarding required.
- Reset values: `hi`=0, `lo`=0, `done`=0, `exe_stall`=0 (given `start` low or `resetn` low).

## Test plan
- MULT a=-3 (32'hFFFFFFFD), b=7 -> HI=32'hFFFFFFFF, LO=32'hFFFFFFEB. `exe_stall` high exactly 34 cycles, `done` pulses in cycle 34.
- MULTU a=32'hFFFFFFFF, b=32'hFFFFFFFF -> HI=32'hFFFFFFFE, LO=32'h00000001.
- DIVU 100/7 -> LO=14, HI=2. DIV -7/2 -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF.
- Boundary cases, each with normal latency:
  - DIV by zero a=5 -> LO=32'hFFFFFFFF, HI=5.
  - DIV 32'h80000000 / 32'hFFFFFFFF -> LO=32'h80000000, HI=0.
- `resetn` low at cycle 10 of a MULT -> next cycle IDLE, HI=LO=0, `exe_stall`=0. A fresh DIVU 9/3 afterwards gives LO=3, HI=0.
- MTHI 32'h1234 in IDLE -> HI=32'h1234 next cycle. `flush` at cycle 20 of a DIVU -> HI/LO keep prior values, no `done` pulse.

Source files
------------

// File: rtl/ex_muldiv.sv
// ex_muldiv -- iterative 32-bit multiply/divide unit with the HI/LO pair,
// sitting in the EX stage of the 5-stage MIPS pipeline.
//
// A MULT/MULTU/DIV/DIVU seen in IDLE is latched as sign flags plus operand
// magnitudes, iterated for 32 cycles (radix-2 shift-add or restoring
// division), sign-corrected and committed to HI/LO, then a one-cycle DONE
// lets the instruction leave EX.
//
// Ports:
//   clk, resetn       clock, synchronous active-low reset
//   start             EX instruction is a mult/div (held while in EX)
//   op[1:0]           00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a[31:0], b[31:0]  rs / rt operands
//   hilo_we[1:0]      MTHI ([1]) / MTLO ([0]) write enables
//   hilo_wdata[31:0]  MTHI/MTLO data
//   flush             abort any in-flight operation
//   exe_stall         hold ID/EX and earlier stages
//   done              one-cycle pulse, result committed
//   hi[31:0], lo[31:0] architectural HI/LO registers
module ex_muldiv (
   input  logic        clk,
   input  logic        resetn,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [1:0]  hilo_we,
   input  logic [31:0] hilo_wdata,
   input  logic        flush,
   output logic        exe_stall,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_SIGN, S_DONE} state_t;

   state_t      state, state_nxt;
   logic [4:0]  cnt;
   logic        take;

   // Operation context latched at acceptance
   logic        is_div_q;
   logic        neg_res_q;   // operand signs differ (signed ops only)
   logic        sign_a_q;    // dividend sign for the remainder
   logic        div_zero_q;
   logic [31:0] md;          // addend (multiply) or divisor (divide)
   logic [31:0] sr;          // multiplier bits (shift right) or dividend bits (shift left)
   logic [63:0] acc;         // product, or {remainder, quotient}

   logic [32:0] mul_sum;
   logic [33:0] div_trial;

   function automatic logic [31:0] abs32(input logic signed [31:0] v);
      return v[31] ? 32'(-v) : 32'(v);
   endfunction

   function automatic logic [31:0] neg32(input logic [31:0] v);
      return ~v + 32'd1;
   endfunction

   function automatic logic [63:0] neg64(input logic [63:0] v);
      return ~v + 64'd1;
   endfunction

   assign take = start && !flush;

   // State register
   always_ff @(posedge clk) begin
      if (!resetn) state <= S_IDLE;
      else         state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (take) state_nxt = S_CALC;
         S_CALC: begin
            if (flush)            state_nxt = S_IDLE;
            else if (cnt == 5'd31) state_nxt = S_SIGN;
         end
         S_SIGN: state_nxt = flush ? S_IDLE : S_DONE;
         S_DONE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Outputs: stall is combinational so ID/EX holds from the first EX cycle
   always_comb begin
      exe_stall = 1'b0;
      done      = 1'b0;
      if (resetn) begin
         exe_stall = ((state == S_IDLE) && take) || (state == S_CALC) || (state == S_SIGN);
         done      = (state == S_DONE);
      end
   end

   // Iteration counter
   always_ff @(posedge clk) begin
      if (!resetn)                        cnt <= 5'd0;
      else if (state == S_IDLE && take)  cnt <= 5'd0;
      else if (state == S_CALC)           cnt <= cnt + 5'd1;
   end

   // One shift-add step: add the addend to the upper half when the current
   // multiplier bit is set, then shift the 65-bit {carry, acc} right.
   assign mul_sum = {1'b0, acc[63:32]} + (sr[0] ? {1'b0, md} : 33'd0);

   // One restoring step: shift the next dividend bit into the partial
   // remainder and subtract; the extra top bit is the borrow.
   assign div_trial = {1'b0, acc[63:32], sr[31]} - {2'b00, md};

   // Datapath (no reset: contents are only meaningful after acceptance)
   always_ff @(posedge clk) begin
      if (state == S_IDLE && take) begin
         is_div_q   <= op[1];
         neg_res_q  <= !op[0] && (a[31] ^ b[31]);
         sign_a_q   <= !op[0] && a[31];
         div_zero_q <= (b == 32'd0);
         acc        <= 64'd0;
         if (op[1]) begin
            md <= op[0] ? b : abs32(b);
            sr <= op[0] ? a : abs32(a);
         end else begin
            md <= op[0] ? a : abs32(a);
            sr <= op[0] ? b : abs32(b);
         end
      end else if (state == S_CALC) begin
         if (!is_div_q) begin
            acc <= {mul_sum, acc[31:1]};
            sr  <= sr >> 1;
         end else begin
            if (!div_trial[33]) acc <= {div_trial[31:0], acc[30:0], 1'b1};
            else                acc <= {acc[62:32], sr[31], acc[30:0], 1'b0};
            sr <= sr << 1;
         end
      end
   end

   // HI/LO: commit at the end of SIGN, otherwise MTHI/MTLO while idle
   always_ff @(posedge clk) begin
      if (!resetn) begin
         hi <= 32'd0;
         lo <= 32'd0;
      end else if (state == S_SIGN && !flush) begin
         if (!is_div_q) begin
            {hi, lo} <= neg_res_q ? neg64(acc) : acc;
         end else begin
            // Divide by zero returns all-ones quotient regardless of signs
            lo <= div_zero_q ? 32'hFFFF_FFFF :
                  (neg_res_q ? neg32(acc[31:0]) : acc[31:0]);
            hi <= sign_a_q ? neg32(acc[63:32]) : acc[63:32];
         end
      end else if (state == S_IDLE) begin
         if (hilo_we[1]) hi <= hilo_wdata;
         if (hilo_we[0]) lo <= hilo_wdata;
      end
   end

endmodule

// File: tb/tb_ex_muldiv.sv
module tb_ex_muldiv;

   logic        clk = 1'b0;
   logic        resetn;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a, b;
   logic [1:0]  hilo_we;
   logic [31:0] hilo_wdata;
   logic        flush;
   logic        exe_stall;
   logic        done;
   logic [31:0] hi, lo;

   int checks = 0;
   int errors = 0;

   ex_muldiv dut (
      .clk        (clk),
      .resetn     (resetn),
      .start      (start),
      .op         (op),
      .a          (a),
      .b          (b),
      .hilo_we    (hilo_we),
      .hilo_wdata (hilo_wdata),
      .flush      (flush),
      .exe_stall  (exe_stall),
      .done       (done),
      .hi         (hi),
      .lo         (lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issue one mult/div at a negedge, hold start until done, then check
   // latency, stall length, the single-cycle done pulse and HI/LO.
   task automatic run_op(input string name, input logic [1:0] o,
                         input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int cyc;
      int stalls;
      cyc    = 0;
      stalls = 0;
      @(negedge clk);
      op    = o;
      a     = x;
      b     = y;
      start = 1'b1;
      #1;
      while (cyc < 100) begin
         if (exe_stall) stalls++;
         if (done) break;
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      check({name, " done_cycle"}, 64'(cyc), 64'd34);
      check({name, " stall_cycles"}, 64'(stalls), 64'd34);
      check({name, " hi"}, {32'd0, hi}, {32'd0, exp_hi});
      check({name, " lo"}, {32'd0, lo}, {32'd0, exp_lo});
      @(negedge clk);
      check({name, " done_pulse_end"}, {63'd0, done}, 64'd0);
   endtask

   initial begin
      int done_seen;
      resetn     = 1'b0;
      start      = 1'b0;
      op         = 2'b00;
      a          = 32'd0;
      b          = 32'd0;
      hilo_we    = 2'b00;
      hilo_wdata = 32'd0;
      flush      = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      check("reset hi", {32'd0, hi}, 64'd0);
      check("reset lo", {32'd0, lo}, 64'd0);
      check("reset done", {63'd0, done}, 64'd0);
      check("reset exe_stall", {63'd0, exe_stall}, 64'd0);
      resetn = 1'b1;

      // start together with flush in IDLE must not stall
      @(negedge clk);
      start = 1'b1;
      flush = 1'b1;
      #1;
      check("start_flush exe_stall", {63'd0, exe_stall}, 64'd0);
      @(negedge clk);
      start = 1'b0;
      flush = 1'b0;
      #1;
      check("start_flush idle", {63'd0, exe_stall}, 64'd0);

      // Main function
      run_op("MULT -3*7",  2'b00, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB);
      run_op("MULTU max",  2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      run_op("DIVU 100/7", 2'b11, 32'd100,       32'd7,         32'd2,         32'd14);
      run_op("DIV -7/2",   2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);

      // Boundaries
      run_op("DIV 5/0",    2'b10, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF);
      run_op("DIV ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000);

      // Reset in the middle of a MULT
      @(negedge clk);
      op    = 2'b00;
      a     = 32'd1234;
      b     = 32'd5678;
      start = 1'b1;
      repeat (10) @(negedge clk);
      resetn = 1'b0;
      start  = 1'b0;
      @(negedge clk);
      check("midreset hi", {32'd0, hi}, 64'd0);
      check("midreset lo", {32'd0, lo}, 64'd0);
      check("midreset exe_stall", {63'd0, exe_stall}, 64'd0);
      check("midreset done", {63'd0, done}, 64'd0);
      resetn = 1'b1;
      run_op("DIVU 9/3",   2'b11, 32'd9,         32'd3,         32'd0,         32'd3);

      // MTHI in IDLE
      @(negedge clk);
      hilo_we    = 2'b10;
      hilo_wdata = 32'h0000_1234;
      @(negedge clk);
      hilo_we = 2'b00;
      check("mthi hi", {32'd0, hi}, 64'h1234);
      check("mthi lo", {32'd0, lo}, 64'd3);

      // Flush during a DIVU
      op    = 2'b11;
      a     = 32'd100;
      b     = 32'd7;
      start = 1'b1;
      repeat (20) @(negedge clk);
      flush = 1'b1;
      start = 1'b0;
      @(negedge clk);
      flush = 1'b0;
      #1;
      check("flush exe_stall", {63'd0, exe_stall}, 64'd0);
      done_seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) done_seen++;
      end
      check("flush no_done", 64'(done_seen), 64'd0);
      check("flush hi", {32'd0, hi}, 64'h1234);
      check("flush lo", {32'd0, lo}, 64'd3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
